// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a PHT of saturating counters, with lookup/mispredict stats.
// Optional gshare PHT indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                f_valid,
    input  logic [31:0]         f_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                u_valid,
    input  logic [31:0]         u_pc,
    input  logic                u_is_branch,
    input  logic                u_is_jump,
    input  logic                u_taken,
    input  logic [31:0]         u_target,
    input  logic [GHR_BITS-1:0] u_ghr,
    input  logic                u_mispred,
    output logic [15:0]         lookup_cnt,
    output logic [15:0]         mispred_cnt
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    function automatic logic [IDX-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
        return pc[IDX+TAG_BITS+1:IDX+2];
    endfunction

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                      input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [15:0] stat_next(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [ENTRIES-1:0]  btb_valid;
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [31:0]         btb_target [ENTRIES];
    logic                btb_jump   [ENTRIES];
    logic [CTR_BITS-1:0] pht        [ENTRIES];

    logic [IDX-1:0]      f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic [IDX-1:0]      f_pidx;
    logic [IDX-1:0]      u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic [IDX-1:0]      u_pidx;
    logic                u_br;
    logic                u_wr;
    logic                hit_raw;
    logic                unused_bits;

    assign f_idx = pc_idx(f_pc);
    assign f_tag = pc_tag(f_pc);
    assign u_idx = pc_idx(u_pc);
    assign u_tag = pc_tag(u_pc);

    // A jump flagged together with a branch is treated purely as a jump: no PHT or history change.
    assign u_br = u_valid & u_is_branch & ~u_is_jump;
    assign u_wr = u_valid & (u_is_branch | u_is_jump) & u_taken;

    assign unused_bits = ^{f_pc, u_pc, u_ghr};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    function automatic logic [IDX-1:0] hist_idx(input logic [GHR_BITS-1:0] g);
        logic [IDX+GHR_BITS-1:0] ext;
        ext = {{IDX{1'b0}}, g};
        return ext[IDX-1:0];
    endfunction

    assign f_pidx   = f_idx ^ hist_idx(ghr);
    assign u_pidx   = u_idx ^ hist_idx(u_ghr);
    assign pred_ghr = ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (u_br)
            ghr <= GHR_BITS'({ghr, u_taken});
    end
`else
    assign f_pidx   = f_idx;
    assign u_pidx   = u_idx;
    assign pred_ghr = '0;
`endif

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign hit_raw     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign pred_hit    = ~reset & hit_raw;
    assign pred_taken  = pred_hit & (btb_jump[f_idx] | pht[f_pidx][CTR_BITS-1]);
    assign pred_target = pred_taken ? btb_target[f_idx] : f_pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                pht[i] <= CTR_INIT;
        end else begin
            if (u_wr)
                btb_valid[u_idx] <= 1'b1;
            if (u_br)
                pht[u_pidx] <= ctr_next(pht[u_pidx], u_taken);
        end
    end

    // Entry payload carries no reset; it is only ever read behind btb_valid.
    always_ff @(posedge clk) begin
        if (u_wr && !reset) begin
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= u_target;
            btb_jump[u_idx]   <= u_is_jump;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookup_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (f_valid)
                lookup_cnt <= stat_next(lookup_cnt);
            if (u_valid && u_mispred)
                mispred_cnt <= stat_next(mispred_cnt);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor in its default (non-gshare) build.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_ghr;
    logic        u_valid;
    logic [31:0] u_pc;
    logic        u_is_branch;
    logic        u_is_jump;
    logic        u_taken;
    logic [31:0] u_target;
    logic [3:0]  u_ghr;
    logic        u_mispred;
    logic [15:0] lookup_cnt;
    logic [15:0] mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .TAG_BITS(8), .GHR_BITS(4)) dut (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_ghr(pred_ghr), .u_valid(u_valid), .u_pc(u_pc),
        .u_is_branch(u_is_branch), .u_is_jump(u_is_jump), .u_taken(u_taken),
        .u_target(u_target), .u_ghr(u_ghr), .u_mispred(u_mispred),
        .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic upd(input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic mis);
        @(negedge clk);
        u_valid = 1'b1; u_pc = pc; u_is_branch = br; u_is_jump = jmp;
        u_taken = tk; u_target = tgt; u_mispred = mis;
        @(negedge clk);
        u_valid = 1'b0; u_is_branch = 1'b0; u_is_jump = 1'b0; u_mispred = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        f_pc = pc;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; f_valid = 1'b0; f_pc = 32'h40; u_valid = 1'b0; u_pc = '0;
        u_is_branch = 1'b0; u_is_jump = 1'b0; u_taken = 1'b0; u_target = '0;
        u_ghr = '0; u_mispred = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL reset_target: got %h want 00000044", pred_target); end
        n_cmp++; if (lookup_cnt !== 16'd0) begin n_err++; $display("FAIL reset_lookup_cnt: got %0d want 0", lookup_cnt); end
        n_cmp++; if (mispred_cnt !== 16'd0) begin n_err++; $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); end
        n_cmp++; if (pred_ghr !== 4'd0) begin n_err++; $display("FAIL reset_ghr: got %h want 0", pred_ghr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cold;
        @(negedge clk);
        f_valid = 1'b1; f_pc = 32'h40;
        #1;
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL cold_hit: got %b want 0", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL cold_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL cold_target: got %h want 00000044", pred_target); end
        repeat (3) @(negedge clk);
        f_valid = 1'b0;
        #1;
        n_cmp++; if (lookup_cnt !== 16'd3) begin n_err++; $display("FAIL cold_lookup_cnt: got %0d want 3", lookup_cnt); end
        look(32'hFFFF_FFFC);
        n_cmp++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL cold_wrap_target: got %h want 00000000", pred_target); end
    endtask

    task automatic test_allocate;
        @(negedge clk);
        f_pc = 32'h40;
        u_valid = 1'b1; u_pc = 32'h40; u_is_branch = 1'b1; u_is_jump = 1'b0;
        u_taken = 1'b1; u_target = 32'h20; u_mispred = 1'b1;
        #1;
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alloc_same_cycle_hit: got %b want 0", pred_hit); end
        n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL alloc_same_cycle_target: got %h want 00000044", pred_target); end
        @(negedge clk);
        u_valid = 1'b0; u_is_branch = 1'b0; u_mispred = 1'b0;
        #1;
        n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit: got %b want 1", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h20) begin n_err++; $display("FAIL alloc_target: got %h want 00000020", pred_target); end
        n_cmp++; if (mispred_cnt !== 16'd1) begin n_err++; $display("FAIL alloc_mispred_cnt: got %0d want 1", mispred_cnt); end
    endtask

    task automatic test_hysteresis;
        repeat (4) upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
        upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h44, 1'b0);
        look(32'h40);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL hyst_one_nt_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h20) begin n_err++; $display("FAIL hyst_one_nt_target: got %h want 00000020", pred_target); end
        upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h44, 1'b0);
        look(32'h40);
        n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL hyst_two_nt_hit: got %b want 1", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL hyst_two_nt_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL hyst_two_nt_target: got %h want 00000044", pred_target); end
    endtask

    task automatic test_alias_jump;
        look(32'h440);
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_miss_hit: got %b want 0", pred_hit); end
        upd(32'h440, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0);
        look(32'h40);
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_evicted_hit: got %b want 0", pred_hit); end
        look(32'h440);
        n_cmp++; if (pred_target !== 32'h500) begin n_err++; $display("FAIL alias_new_target: got %h want 00000500", pred_target); end
        upd(32'h440, 1'b1, 1'b0, 1'b0, 32'h444, 1'b0);
        look(32'h440);
        n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL alias_nt_hit: got %b want 1", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_nt_taken: got %b want 0", pred_taken); end
        upd(32'h80, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        look(32'h80);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jump_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h100) begin n_err++; $display("FAIL jump_target: got %h want 00000100", pred_target); end
        look(32'h440);
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL jump_evict_hit: got %b want 0", pred_hit); end
    endtask

    task automatic test_priority;
        upd(32'h84, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        look(32'h84);
        n_cmp++; if (pred_target !== 32'h200) begin n_err++; $display("FAIL prio_jump_target: got %h want 00000200", pred_target); end
        upd(32'h84, 1'b1, 1'b0, 1'b1, 32'h210, 1'b0);
        upd(32'h84, 1'b1, 1'b0, 1'b0, 32'h88, 1'b0);
        look(32'h84);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL prio_pht_untouched_taken: got %b want 0", pred_taken); end
        upd(32'h88, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        look(32'h88);
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL neither_no_alloc_hit: got %b want 0", pred_hit); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        u_valid = 1'b1; u_is_branch = 1'b1; u_is_jump = 1'b0; u_taken = 1'b1;
        u_pc = 32'h48; u_target = 32'h600;
        @(negedge clk);
        u_pc = 32'h4C; u_target = 32'h604;
        @(negedge clk);
        u_valid = 1'b0; u_is_branch = 1'b0;
        look(32'h48);
        n_cmp++; if (pred_target !== 32'h600) begin n_err++; $display("FAIL b2b_first_target: got %h want 00000600", pred_target); end
        look(32'h4C);
        n_cmp++; if (pred_target !== 32'h604) begin n_err++; $display("FAIL b2b_second_target: got %h want 00000604", pred_target); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        f_pc = 32'h84;
        u_valid = 1'b1; u_pc = 32'h90; u_is_branch = 1'b1; u_is_jump = 1'b0;
        u_taken = 1'b1; u_target = 32'h999; u_mispred = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL areset_hit: got %b want 0", pred_hit); end
        n_cmp++; if (pred_target !== 32'h88) begin n_err++; $display("FAIL areset_target: got %h want 00000088", pred_target); end
        n_cmp++; if (lookup_cnt !== 16'd0) begin n_err++; $display("FAIL areset_lookup_cnt: got %0d want 0", lookup_cnt); end
        @(negedge clk);
        u_valid = 1'b0; u_is_branch = 1'b0; u_mispred = 1'b0;
        reset = 1'b0;
        look(32'h90);
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL areset_no_write_hit: got %b want 0", pred_hit); end
        n_cmp++; if (mispred_cnt !== 16'd0) begin n_err++; $display("FAIL areset_mispred_cnt: got %0d want 0", mispred_cnt); end
        upd(32'h48, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0);
        look(32'h48);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL areset_pht_init_up: got %b want 1", pred_taken); end
        upd(32'h48, 1'b1, 1'b0, 1'b0, 32'h4C, 1'b0);
        look(32'h48);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL areset_pht_init_down: got %b want 0", pred_taken); end
    endtask

    task automatic test_stats_sat;
        @(negedge clk);
        f_valid = 1'b1; u_valid = 1'b1; u_mispred = 1'b1;
        u_is_branch = 1'b0; u_is_jump = 1'b0;
        repeat (65534) @(negedge clk);
        #1;
        n_cmp++; if (mispred_cnt !== 16'hFFFE) begin n_err++; $display("FAIL stats_mispred_pre: got %h want fffe", mispred_cnt); end
        n_cmp++; if (lookup_cnt !== 16'hFFFE) begin n_err++; $display("FAIL stats_lookup_pre: got %h want fffe", lookup_cnt); end
        repeat (6) @(negedge clk);
        f_valid = 1'b0; u_valid = 1'b0; u_mispred = 1'b0;
        #1;
        n_cmp++; if (mispred_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stats_mispred_sat: got %h want ffff", mispred_cnt); end
        n_cmp++; if (lookup_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stats_lookup_sat: got %h want ffff", lookup_cnt); end
    endtask

    initial begin
        test_reset;
        test_cold;
        test_allocate;
        test_hysteresis;
        test_alias_jump;
        test_priority;
        test_back_to_back;
        test_async_reset;
        test_stats_sat;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined RISC-V core.
- Sits beside InstMem in the IF stage. Gives a same-cycle taken/target prediction for the fetch PC.
- Trained from the EX stage when a branch or jump resolves.
- Combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of saturating counters, plus lookup and mispredict statistics counters for the LED/SSD debug path.

Parameters:
- ENTRIES, 16: BTB and PHT depth; power of two, at least 4. IDX = log2(ENTRIES).
- CTR_BITS, 2: width of each PHT saturating counter.
- TAG_BITS, 8: BTB tag width.
- GHR_BITS, 4: global history width, used only with GSHARE_EN; must be at least IDX or is zero-extended.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- f_valid  in  1  fetch lookup valid (counts lookups).
- f_pc  in  32  fetch PC.
- pred_hit  out  1  BTB valid and tag match for f_pc.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- pred_ghr  out  GHR_BITS  GHR snapshot to carry down the pipe; 0 without GSHARE_EN.
- u_valid  in  1  resolve update strobe (EX stage).
- u_pc  in  32  PC of the resolved instruction.
- u_is_branch  in  1  conditional branch.
- u_is_jump  in  1  JAL.
- u_taken  in  1  actual outcome.
- u_target  in  32  actual target.
- u_ghr  in  GHR_BITS  pred_ghr value returned with the instruction.
- u_mispred  in  1  pipeline detected a mispredict.
- lookup_cnt  out  16  saturating count of f_valid cycles.
- mispred_cnt  out  16  saturating count of u_valid & u_mispred.

Behaviour:
- Indexing: idx(pc) = pc[IDX+1:2]; tag(pc) = pc[IDX+TAG_BITS+1:IDX+2].
- BTB entry fields: valid, tag, target[31:0], jump bit.
- PHT index: pidx = idx(pc), or idx ^ ghr[IDX-1:0] with GSHARE_EN.
- Lookup is combinational, zero latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jump | PHT[pidx][CTR_BITS-1]).
  - pred_target = pred_taken ? target : f_pc+4, wrapping at 2^32.
- PHT update, on posedge when u_valid & u_is_branch:
  - u_taken: PHT[pidx(u_pc)] increments, saturating at 2^CTR_BITS-1.
  - else: decrements, saturating at 0.
- BTB update, on posedge when u_valid & (u_is_branch | u_is_jump):
  - Tag hit and u_taken: overwrite target; set jump bit = u_is_jump.
  - Tag miss (or invalid) and u_taken: allocate the entry (valid=1, tag, target, jump bit), evicting any alias.
  - Not-taken miss: no allocation. Not-taken hit: BTB unchanged.
- u_valid with neither u_is_branch nor u_is_jump: no table change. u_is_jump takes priority if both are set.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (no bypass). The new value is visible the next cycle.
- Statistics counters:
  - lookup_cnt increments on f_valid; mispred_cnt on u_valid & u_mispred.
  - Both stick at 16'hFFFF. Both may increment in the same cycle.
- Reset (async, any time, including mid-update):
  - All BTB valid = 0.
  - All PHT counters = 2^(CTR_BITS-1)-1 (weakly not-taken).
  - GHR = 0; both statistics counters = 0.
  - While reset is high: pred_hit = 0, pred_taken = 0, pred_target = f_pc+4. Updates are ignored.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A GHR_BITS global history register shifts left, inserting u_taken, on each u_valid & u_is_branch.
  - pred_ghr = GHR.
  - Lookup pidx uses the current GHR; update pidx uses u_ghr.
  - The BTB stays indexed by PC only.
- Undefined: no GHR; pred_ghr = 0; u_ghr ignored; pidx = idx(pc).

Test Plan:
- Cold lookup: reset, then f_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; lookup_cnt increments by 1 per f_valid cycle.
- Allocate: update u_pc=0x40 branch, taken, target 0x20 -> next cycle f_pc=0x40 gives hit=1, taken=1, target=0x20. The same-cycle lookup still shows target 0x44.
- Hysteresis/saturation (CTR_BITS=2): four taken updates at 0x40 saturate the counter at 3. One not-taken -> still taken. A second not-taken -> taken=0, target=0x44, hit=1.
- Alias/jump: f_pc=0x440 (idx 0, tag 0x11) -> hit=0. JAL update u_pc=0x80, target 0x100 -> f_pc=0x80 taken=1 regardless of counter; later a taken branch update at 0x440 evicts 0x40 -> f_pc=0x40 hit=0.
- Async reset mid-update: assert reset between edges while u_valid=1 -> outputs go to reset values immediately; no entry is written; mispred_cnt=0.
- Stats saturation: force 65536 mispredict updates -> mispred_cnt holds 0xFFFF.
